mips_cpu_bus_arbiter: RTL and testbench
=======================================

Name: mips_cpu_bus_arbiter

Overview:
Two-master, one-slave arbiter that shares the single byte-addressed CPU memory bus between the instruction-fetch port (m0) and the data load/store port (m1). It sequences each transfer to the memory: grant, issue, honour slave waitrequest, wait the fixed read latency, capture readdata, then release the master. Round-robin arbitration prevents starvation of either port.

Parameters:
ADDR_W, 32, address width on master and slave ports
READ_LATENCY, 1, cycles from accepted slave read (read=1, waitrequest=0) to valid s_readdata; legal range 1..7

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
m0_read  input  1  master 0 read request
m0_write  input  1  master 0 write request
m0_addr  input  ADDR_W  master 0 byte address
m0_byteenable  input  4  master 0 byte enables
m0_writedata  input  32  master 0 write data
m0_waitrequest  output  1  high = stall master 0
m0_readdata  output  32  master 0 read data, valid when m0_waitrequest low after a read
m1_read, m1_write, m1_addr, m1_byteenable, m1_writedata, m1_waitrequest, m1_readdata  same directions, widths and meanings as the m0 ports, for master 1
s_read  output  1  slave read strobe
s_write  output  1  slave write strobe
s_addr  output  ADDR_W  slave address
s_byteenable  output  4  slave byte enables
s_writedata  output  32  slave write data
s_waitrequest  input  1  slave stall
s_readdata  input  32  slave read data

Behaviour:
- Request: mX_req = mX_read XOR mX_write. If read and write are both high, the arbiter treats it as no request and never grants it. Its waitrequest stays high.
- FSM states: IDLE, ISSUE, RDWAIT, DONE.
- IDLE:
  - If exactly one master requests, grant it.
  - If both request, grant the master that was not granted last. The last-grant register resets to m1, so m0 wins the first tie.
  - On grant, latch op, addr, byteenable and writedata into registers, update last-grant, and go to ISSUE.
- ISSUE: drive the s_* outputs from the latched registers, with exactly one of s_read or s_write high.
  - If s_waitrequest is high, stay in ISSUE and hold all s_* outputs stable.
  - If s_waitrequest is low and op is write, go to DONE.
  - If s_waitrequest is low and op is read, load the latency counter with READ_LATENCY and go to RDWAIT.
- RDWAIT: s_read and s_write are low.
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture s_readdata into the granted master's readdata register and go to DONE.
  - With READ_LATENCY=1, RDWAIT lasts exactly 1 cycle.
- DONE:
  - Granted master's waitrequest is low for exactly one cycle. For a read, its readdata holds the captured word.
  - Go to IDLE. Requests are not sampled in DONE, so a held strobe is not re-serviced.
- waitrequest for each master: high in every cycle except that master's DONE cycle, including while idle with no request.
- mX_readdata: holds its last captured value until the next read to that master.
- s_* outputs: s_read and s_write are 0 outside ISSUE. s_addr, s_byteenable and s_writedata hold the latched values at all times.
- Latency, no slave stall:
  - Write: grant cycle, issue cycle, DONE cycle, so the master sees waitrequest low 3 cycles after first asserting its request.
  - Read: 3 + READ_LATENCY cycles.
- Master inputs are ignored after latching; the latched values are used.
- Reset: asynchronous on reset_n low, and valid at any time including mid-transfer.
  - State goes to IDLE; s_read and s_write go to 0 immediately.
  - m0_waitrequest and m1_waitrequest go to 1.
  - m0_readdata, m1_readdata, s_addr, s_byteenable, s_writedata and the counter go to 0.
  - Last-grant goes to m1.
  - A transfer interrupted by reset is abandoned. It is not replayed.

Test Plan:
- Single write:
  - Stimulus: m1_write, addr 0x100, be 4'b1111, data 0xDEADBEEF, slave never stalls.
  - Response: s_write high for 1 cycle with those values. m1_waitrequest is low exactly on cycle 3, then high again.
- Single read:
  - Stimulus: m0_read addr 0x100 with memory holding 0xDEADBEEF, READ_LATENCY=1.
  - Response: m0_waitrequest low on cycle 4 with m0_readdata=0xDEADBEEF. m1_waitrequest stays high throughout.
- Contention:
  - Stimulus: m0 and m1 both request reads from reset and hold the request until served.
  - Response: order is m0, m1, m0, m1 for repeated requests, and neither master waits more than one foreign transfer.
- Slave stall:
  - Stimulus: s_waitrequest forced high for 5 cycles during ISSUE.
  - Response: s_read, s_addr and s_byteenable stay stable for all 6 cycles, then the normal completion follows.
- Illegal request and readdata hold:
  - Stimulus: m0_read and m0_write both high while m1_write requests.
  - Response: only m1 is granted, m0_waitrequest stays high, and m0_readdata is unchanged.
- Reset mid-read:
  - Stimulus: reset_n pulled low during RDWAIT.
  - Response: s_read=0, both waitrequests=1 and readdata=0 immediately. After release, the first tie is granted to m0.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-master round-robin arbiter sharing the CPU memory bus between instruction
// fetch (m0) and load/store (m1); sequences grant, issue, slave stall and read latency.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [3:0]        s_byteenable,
  output logic [31:0]       s_writedata,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              m0_req, m1_req, pick_m1;

  // Read and write together is malformed and never counts as a request.
  assign m0_req  = m0_read ^ m0_write;
  assign m1_req  = m1_read ^ m1_write;
  assign pick_m1 = m1_req && (!m0_req || !last_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d    = pick_m1;
          last_d     = pick_m1;
          op_write_d = pick_m1 ? m1_write : m0_write;
          addr_d     = pick_m1 ? m1_addr : m0_addr;
          be_d       = pick_m1 ? m1_byteenable : m0_byteenable;
          wdata_d    = pick_m1 ? m1_writedata : m0_writedata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_waitrequest) begin
          if (op_write_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          cnt_d = '0;
          if (grant_q) m1_rdata_d = s_readdata;
          else         m0_rdata_d = s_readdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_read         = (state_q == ISSUE) && !op_write_q;
  assign s_write        = (state_q == ISSUE) && op_write_q;
  assign s_addr         = addr_q;
  assign s_byteenable   = be_q;
  assign s_writedata    = wdata_q;
  assign m0_waitrequest = !((state_q == DONE) && !grant_q);
  assign m1_waitrequest = !((state_q == DONE) && grant_q);
  assign m0_readdata    = m0_rdata_q;
  assign m1_readdata    = m1_rdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: table-driven single transfers, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_mips_cpu_bus_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_addr, m1_addr, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [31:0] s_addr, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.ADDR_W(32), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
  );

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          pre;
    logic [31:0] preload;
    int          stall;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  int          applied = 0;
  int          miscompares = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          stall_left = 0;
  bit          rand_stall = 0;
  int          cd = 0;
  logic [31:0] rd_word = '0;

  bit          pend [2];
  bit          pwr [2];
  logic [31:0] paddr [2];
  logic [31:0] pdata [2];
  logic [3:0]  pbe [2];
  int          gap [2];
  int          ill [2];
  int          fcount [2];
  bit          wrv [2];
  logic [31:0] rdv [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory slave: data appears only in the cycle the arbiter should capture it.
  task automatic slave_step();
    if ((s_read || s_write) && stall_left > 0) begin
      s_waitrequest = 1'b1;
      stall_left--;
    end else if ((s_read || s_write) && rand_stall) begin
      s_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      s_waitrequest = 1'b0;
    end
    if (cd > 0) cd--;
    if (s_read && !s_waitrequest) begin
      cd      = LAT + 1;
      rd_word = mem[s_addr[5:2]];
    end
    if (s_write && !s_waitrequest)
      mem[s_addr[5:2]] = merge(mem[s_addr[5:2]], s_writedata, s_byteenable);
    s_readdata = (cd == 1) ? rd_word : (32'hBAD0_0000 | 32'(cd));
  endtask

  task automatic step();
    @(negedge clk);
    slave_step();
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_addr = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_addr = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cd = 0;
    stall_left = 0;
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic apply_vector(input int idx, input vec_t v);
    int lat, strobes;
    bit stable, other_low, done;
    logic own_wr;
    if (v.pre) mem[v.addr[5:2]] = v.preload;
    drive(v.m, !v.wr, v.wr, v.addr, v.be, v.wdata);
    stall_left = v.stall;
    lat = 1; strobes = 0; stable = 1'b1; other_low = 1'b0; done = 1'b0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (s_read || s_write) begin
        strobes++;
        if (s_read !== !v.wr || s_write !== v.wr || s_addr !== v.addr ||
            s_byteenable !== v.be || (v.wr && s_writedata !== v.wdata)) stable = 1'b0;
      end
      if ((v.m ? m0_waitrequest : m1_waitrequest) == 1'b0) other_low = 1'b1;
      if ((v.m ? m1_waitrequest : m0_waitrequest) == 1'b0) done = 1'b1;
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("vec%0d_strobe_cycles", idx), 32'(strobes), 32'(1 + v.stall));
    check($sformatf("vec%0d_slave_stable", idx), 32'(stable), 32'd1);
    check($sformatf("vec%0d_other_waitreq_high", idx), 32'(other_low), 32'd0);
    if (!v.wr)
      check($sformatf("vec%0d_readdata", idx), v.m ? m1_readdata : m0_readdata, v.exp_rdata);
    drive(v.m, 0, 0, 32'h0, 4'h0, 32'h0);
    step();
    own_wr = v.m ? m1_waitrequest : m0_waitrequest;
    check($sformatf("vec%0d_waitreq_after_done", idx), 32'(own_wr), 32'd1);
  endtask

  initial begin
    vec_t vt [9];
    int   ord [4];
    int   n, lat, first, r, done_cnt;
    bit   m0_low;
    logic [31:0] saved;

    vt[0] = '{1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 0, 3, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h0, 0, 3 + LAT, 32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b1, 32'h104, 4'h3, 32'h11223344, 1'b1, 32'hAAAAAAAA, 0, 3, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 1'b0, 32'h0, 0, 3 + LAT, 32'hAAAA3344};
    vt[4] = '{1'b1, 1'b1, 32'h108, 4'hC, 32'hCAFEF00D, 1'b1, 32'h01234567, 2, 5, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h108, 4'hF, 32'h0, 1'b0, 32'h0, 5, 8 + LAT, 32'hCAFE4567};
    vt[6] = '{1'b1, 1'b0, 32'h10C, 4'h5, 32'h0, 1'b1, 32'h5A5AA5A5, 1, 4 + LAT, 32'h5A5AA5A5};
    vt[7] = '{1'b0, 1'b1, 32'h10C, 4'h8, 32'h77000000, 1'b0, 32'h0, 0, 3, 32'h0};
    vt[8] = '{1'b0, 1'b0, 32'h10C, 4'hF, 32'h0, 1'b0, 32'h0, 0, 3 + LAT, 32'h775AA5A5};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    s_waitrequest = 1'b0;
    s_readdata = 32'h0;
    reset_n = 1'b0;
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("reset_m0_waitreq", 32'(m0_waitrequest), 32'd1);
    check("reset_m1_waitreq", 32'(m1_waitrequest), 32'd1);
    check("reset_s_strobes", {30'd0, s_read, s_write}, 32'd0);
    check("reset_m0_readdata", m0_readdata, 32'h0);
    check("reset_s_addr", s_addr, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_vector(i, vt[i]);

    // Both masters hold reads from reset: service must alternate starting at m0.
    do_reset();
    mem[4] = 32'h13572468;
    mem[5] = 32'h24681357;
    drive(0, 1, 0, 32'h110, 4'hF, 32'h0);
    drive(1, 1, 0, 32'h114, 4'hF, 32'h0);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      if (!m0_waitrequest) begin
        check("contend_m0_readdata", m0_readdata, 32'h13572468);
        ord[n] = 0; n++;
      end
      if (!m1_waitrequest && n < 4) begin
        check("contend_m1_readdata", m1_readdata, 32'h24681357);
        ord[n] = 1; n++;
      end
    end
    check("contend_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("contend_order%0d", i), 32'(ord[i]), 32'(i % 2));
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    step();
    step();

    // Malformed m0 request alongside a legal m1 write.
    saved = m0_readdata;
    drive(0, 1, 1, 32'h110, 4'hF, 32'h0);
    drive(1, 0, 1, 32'h118, 4'hF, 32'h0F0F0F0F);
    m0_low = 1'b0;
    lat = 1;
    while (m1_waitrequest && lat < 20) begin
      step();
      lat++;
      if (!m0_waitrequest) m0_low = 1'b1;
    end
    check("illegal_m1_latency", 32'(lat), 32'd3);
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (6) begin
      step();
      if (!m0_waitrequest) m0_low = 1'b1;
    end
    check("illegal_m0_never_granted", 32'(m0_low), 32'd0);
    check("illegal_m0_readdata_held", m0_readdata, saved);
    check("illegal_write_landed", mem[6], 32'h0F0F0F0F);
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    step();

    // Reset during RDWAIT of an m0 read, so last-grant is m0 when reset hits.
    drive(0, 1, 0, 32'h110, 4'hF, 32'h0);
    step();
    step();
    check("rstmid_in_rdwait", {30'd0, s_read, m0_waitrequest}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_s_strobes", {30'd0, s_read, s_write}, 32'd0);
    check("rstmid_waitreqs", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
    check("rstmid_m0_readdata", m0_readdata, 32'h0);
    check("rstmid_m1_readdata", m1_readdata, 32'h0);
    check("rstmid_s_addr", s_addr, 32'h0);
    cd = 0;
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 1, 32'h120, 4'hF, 32'h11111111);
    drive(1, 0, 1, 32'h124, 4'hF, 32'h22222222);
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      step();
      if (!m0_waitrequest) first = 0;
      else if (!m1_waitrequest) first = 1;
    end
    check("rstmid_first_tie_winner", 32'(first), 32'd0);
    drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (12) step();
    drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();

    // Random traffic with random slave stalls against the transaction model.
    rand_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; gap[m] = 0; ill[m] = 0; fcount[m] = 0;
    end
    done_cnt = 0;
    for (int cyc = 0; cyc < 1560; cyc++) begin
      step();
      wrv[0] = m0_waitrequest; wrv[1] = m1_waitrequest;
      rdv[0] = m0_readdata;    rdv[1] = m1_readdata;
      for (int m = 0; m < 2; m++) begin
        if (!wrv[m]) begin
          done_cnt++;
          check($sformatf("rand_m%0d_legal_grant", m), 32'(pend[m]), 32'd1);
          check($sformatf("rand_m%0d_exclusive_done", m), 32'(wrv[1-m]), 32'd1);
          check($sformatf("rand_m%0d_fairness", m), 32'(fcount[m] <= 1), 32'd1);
          if (pend[m] && !pwr[m])
            check($sformatf("rand_m%0d_readdata", m), rdv[m], ref_mem[paddr[m][5:2]]);
          else if (pend[m])
            ref_mem[paddr[m][5:2]] = merge(ref_mem[paddr[m][5:2]], pdata[m], pbe[m]);
          if (pend[1-m]) fcount[1-m]++;
          pend[m] = 1'b0;
          gap[m] = $urandom_range(0, 3);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if (ill[m] > 0) begin
            ill[m]--;
            drive(m, 1, 1, 32'h13C, 4'hF, 32'h0);
          end else if (gap[m] > 0) begin
            gap[m]--;
            drive(m, 0, 0, 32'h0, 4'h0, 32'h0);
          end else if (cyc < 1500) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
              ill[m] = $urandom_range(1, 4);
              drive(m, 1, 1, 32'h13C, 4'hF, 32'h0);
            end else if (r < 6) begin
              pend[m]   = 1'b1;
              fcount[m] = 0;
              pwr[m]    = 1'($urandom_range(0, 1));
              paddr[m]  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
              pbe[m]    = 4'($urandom_range(1, 15));
              pdata[m]  = $urandom;
              drive(m, !pwr[m], pwr[m], paddr[m], pbe[m], pdata[m]);
            end else begin
              drive(m, 0, 0, 32'h0, 4'h0, 32'h0);
            end
          end else begin
            drive(m, 0, 0, 32'h0, 4'h0, 32'h0);
          end
        end
      end
    end
    check("rand_all_drained", {30'd0, pend[0], pend[1]}, 32'd0);
    check("rand_enough_traffic", 32'(done_cnt >= 100), 32'd1);
    for (int i = 0; i < 16; i++) check($sformatf("rand_mem%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
